serial_word_collector: RTL and testbench

Bit-serial to parallel collector sitting directly downstream of the serial two's-complement stage. It accepts that stage's result stream one bit per qualified clock, LSB first, framed by start/end-of-frame markers. It assembles each frame into a sign-extended WIDTH-bit word and emits the word with a one-cycle valid pulse, flagging frames longer than WIDTH.

---
 rtl/serial_word_collector.sv | 104 ++++++++++
 tb/tb_serial_word_collector.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_collector.sv
// Bit-serial to parallel collector. It assembles LSB-first frames into sign-extended words
// and pulses word_valid on the edge that completes a frame.
module serial_word_collector #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             sof,
    input  logic             eof,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             overflow,
    output logic [CW-1:0]    bit_count,
    output logic             busy
);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sticky_q, sticky_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic               ovf_q, ovf_d;
    logic               wv_q, wv_d;
    logic               done;
    logic               msb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            word_q   <= '0;
            ovf_q    <= 1'b0;
            wv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            word_q   <= word_d;
            ovf_q    <= ovf_d;
            wv_q     <= wv_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        word_d   = word_q;
        ovf_d    = ovf_q;
        wv_d     = 1'b0;
        done     = 1'b0;
        msb      = 1'b0;

        if (bit_valid) begin
            if (sof) begin
                // A sof always starts a fresh frame, discarding any partial one.
                sreg_d[0] = bit_in;
                cnt_d     = CW'(1);
                sticky_d  = 1'b0;
                state_d   = COLLECT;
                done      = eof;
            end else if (state_q == COLLECT) begin
                if (cnt_q == CW'(WIDTH)) begin
                    sticky_d = 1'b1;
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (CW'(i) == cnt_q) sreg_d[i] = bit_in;
                    end
                    cnt_d = cnt_q + CW'(1);
                end
                done = eof;
            end
        end

        if (done) begin
            // Result is built from the post-update storage so the eof bit is included.
            for (int j = 0; j < WIDTH; j++) begin
                if (CW'(j + 1) == cnt_d) msb = sreg_d[j];
            end
            for (int i = 0; i < WIDTH; i++) begin
                word_d[i] = (CW'(i) < cnt_d) ? sreg_d[i] : msb;
            end
            ovf_d   = sticky_d;
            wv_d    = 1'b1;
            state_d = IDLE;
        end
    end

    assign word_out   = word_q;
    assign word_valid = wv_q;
    assign overflow   = ovf_q;
    assign bit_count  = cnt_q;
    assign busy       = (state_q == COLLECT);

endmodule

// File: tb/tb_serial_word_collector.sv
// Randomized and directed bench for serial_word_collector, checked against a frame-level
// reference model that works from a queue of accepted bits.
module tb_serial_word_collector;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          bit_in = 1'b0;
    logic          bit_valid = 1'b0;
    logic          sof = 1'b0;
    logic          eof = 1'b0;
    logic [W-1:0]  word_out;
    logic          word_valid;
    logic          overflow;
    logic [CW-1:0] bit_count;
    logic          busy;

    serial_word_collector #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .sof        (sof),
        .eof        (eof),
        .word_out   (word_out),
        .word_valid (word_valid),
        .overflow   (overflow),
        .bit_count  (bit_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit       q[$];
    int       total_bits;
    bit       in_frame;
    bit [W-1:0] exp_word;
    bit       exp_wv, exp_ovf, exp_busy;
    int       exp_cnt;
    int       pulses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        total_bits = 0;
        in_frame   = 0;
        exp_word   = '0;
        exp_wv     = 0;
        exp_ovf    = 0;
        exp_busy   = 0;
        exp_cnt    = 0;
    endtask

    task automatic model_edge(input bit v, input bit s, input bit e, input bit b);
        int n;
        int val;
        exp_wv = 0;
        if (!v) return;
        if (s) begin
            q.delete();
            q.push_back(b);
            total_bits = 1;
            in_frame   = 1;
        end else if (in_frame) begin
            total_bits++;
            if (q.size() < W) q.push_back(b);
        end else begin
            return;
        end
        if (e) begin
            n   = q.size();
            val = 0;
            for (int i = 0; i < n; i++) val += int'(q[i]) << i;
            if (q[n-1]) val -= (1 << n);
            exp_word = val[W-1:0];
            exp_ovf  = (total_bits > W);
            exp_wv   = 1;
            in_frame = 0;
        end
        exp_cnt  = q.size();
        exp_busy = in_frame;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".word"}, 32'(word_out), 32'(exp_word));
        check({tag, ".wv"}, 32'(word_valid), 32'(exp_wv));
        check({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
        check({tag, ".cnt"}, 32'(bit_count), 32'(exp_cnt));
        check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    endtask

    task automatic step(input bit v, input bit s, input bit e, input bit b, input string tag);
        bit_valid = v;
        sof       = s;
        eof       = e;
        bit_in    = b;
        @(posedge clk);
        model_edge(v, s, e, b);
        #1;
        if (word_valid) pulses++;
        check_all(tag);
    endtask

    task automatic idle_gap(input string tag);
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tag);
    endtask

    // gap_pct: chance of a bit_valid=0 cycle before each bit; with_eof=0 leaves frame open
    task automatic send_frame(input logic [15:0] bits, input int len, input int gap_pct,
                              input bit with_eof, input string tag);
        for (int k = 0; k < len; k++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle_gap(tag);
            step(1'b1, k == 0, with_eof && (k == len - 1), bits[k], tag);
        end
    endtask

    initial begin
        model_reset();
        pulses = 0;
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // 0xD3: bits 1,1,0,0,1,0,1,1
        pulses = 0;
        send_frame(16'h00D3, 8, 0, 1'b1, "d3");
        check("d3.const", 32'(word_out), 32'hD3);
        check("d3.pulses", 32'(pulses), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, "d3.after");

        // -3 then 0x03 back to back
        pulses = 0;
        send_frame(16'h001D, 5, 0, 1'b1, "m3");
        check("m3.const", 32'(word_out), 32'hFD);
        send_frame(16'h0003, 4, 0, 1'b1, "p3");
        check("p3.const", 32'(word_out), 32'h03);
        check("b2b.pulses", 32'(pulses), 32'd2);

        // overflow frame, then a clean frame clears overflow
        send_frame(16'h035A, 10, 0, 1'b1, "ovf");
        check("ovf.const", 32'(word_out), 32'h5A);
        check("ovf.flag", 32'(overflow), 32'd1);
        check("ovf.cnt", 32'(bit_count), 32'd8);
        send_frame(16'h00A5, 8, 0, 1'b1, "clr");
        check("clr.flag", 32'(overflow), 32'd0);

        // bit_valid gaps
        pulses = 0;
        send_frame(16'h0081, 8, 60, 1'b1, "gap");
        check("gap.const", 32'(word_out), 32'h81);
        check("gap.pulses", 32'(pulses), 32'd1);

        // restart after 3 bits, then stray eof in IDLE
        pulses = 0;
        send_frame(16'h0007, 3, 0, 1'b0, "abort");
        send_frame(16'h003C, 8, 0, 1'b1, "3c");
        check("3c.const", 32'(word_out), 32'h3C);
        check("3c.pulses", 32'(pulses), 32'd1);
        step(1'b1, 1'b0, 1'b1, 1'b1, "stray");
        check("stray.wv", 32'(word_valid), 32'd0);

        // asynchronous reset mid-frame
        send_frame(16'h000F, 4, 0, 1'b0, "pre_rst");
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b1, 1'b1, 1'b1, "one");
        check("one.const", 32'(word_out), 32'hFF);

        // continuous 1-bit frames
        pulses = 0;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1)), "cont");
        check("cont.pulses", 32'(pulses), 32'd6);

        // random frames: lengths 1..12, random gaps, some left open to be restarted
        for (int f = 0; f < 60; f++) begin
            send_frame(16'($urandom), $urandom_range(1, 12), $urandom_range(0, 40),
                       $urandom_range(0, 5) != 0, "rnd");
            if ($urandom_range(0, 3) == 0) idle_gap("rnd.gap");
            if ($urandom_range(0, 7) == 0) step(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)), "rnd.stray");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
